// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (port 0)
// and load (port 1) writeback, with a registered write port and pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AW-1:0]     req0_rd,
  input  logic [XLEN-1:0]   req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AW-1:0]     req1_rd,
  input  logic [XLEN-1:0]   req1_data,
  input  logic              mark_valid,
  input  logic [AW-1:0]     mark_rd,
  output logic [2**AW-1:0]  busy,
  output logic              rf_we,
  output logic [AW-1:0]     rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);
  localparam int NREG = 2**AW;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic            ptr;  // 0: req0 wins a tie, 1: req1 wins a tie
  logic            gnt0, gnt1, any_gnt;
  wb_req_t         sel;
  logic [NREG-1:0] busy_q, busy_nxt;

  assign gnt0    = req0_valid && (!req1_valid || !ptr);
  assign gnt1    = req1_valid && (!req0_valid ||  ptr);
  assign any_gnt = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    sel = '{rd: req0_rd, data: req0_data};
    if (gnt1) sel = '{rd: req1_rd, data: req1_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= any_gnt && (sel.rd != '0);
      if (any_gnt) begin
        ptr      <= gnt0;
        rf_rd    <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

  // Clear first, then set, so a new producer marking the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (any_gnt) busy_nxt[sel.rd] = 1'b0;
    if (mark_valid) busy_nxt[mark_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes expected register-file writes, a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_ready;
  logic [AW-1:0]     req0_rd;
  logic [XLEN-1:0]   req0_data;
  logic              req1_valid, req1_ready;
  logic [AW-1:0]     req1_rd;
  logic [XLEN-1:0]   req1_data;
  logic              mark_valid;
  logic [AW-1:0]     mark_rd;
  logic [2**AW-1:0]  busy;
  logic              rf_we;
  logic [AW-1:0]     rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  int  n_pass = 0;
  int  n_total = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .mark_valid(mark_valid), .mark_rd(mark_rd), .busy(busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every write the register file sees must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_rd, rf_wdata}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_rd_data", {27'd0, rf_rd, rf_wdata}, {27'd0, w.rd, w.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    mark_valid = 1'b0; mark_rd = '0;

    // Reset with random inputs: nothing may escape
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_rd = AW'($urandom); req1_rd = AW'($urandom);
      req0_data = $urandom; req1_data = $urandom;
      mark_valid = 1'b1; mark_rd = AW'($urandom_range(1, 31));
      tick();
      chk("reset_rf_we", 64'(rf_we), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; mark_valid = 1'b0;
    #1;
    chk("idle_ready0", 64'(req0_ready), 64'd0);
    chk("idle_ready1", 64'(req1_ready), 64'd0);
    chk("reset_rf_rd", 64'(rf_rd), 64'd0);
    chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single requester
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_ready0", 64'(req0_ready), 64'd1);
    chk("single_ready1", 64'(req1_ready), 64'd0);
    push(5'd5, 32'hDEADBEEF);
    tick();
    req0_valid = 1'b0;
    chk("single_we_hi", 64'(rf_we), 64'd1);
    tick();
    chk("single_we_lo", 64'(rf_we), 64'd0);

    // Reset while rf_we is high: the accepted write is lost
    req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'h66;
    tick();
    req0_valid = 1'b0;
    chk("pre_reset_we", 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_we", 64'(rf_we), 64'd0);
    chk("async_reset_rd", 64'(rf_rd), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Contention, both held: grants alternate 0,1,0,1 from reset
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ready0", 64'(req0_ready), 64'((i % 2) == 0));
      chk("cont_ready1", 64'(req1_ready), 64'((i % 2) == 1));
      if ((i % 2) == 0) push(5'd3, 32'h11);
      else              push(5'd4, 32'h22);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Lone req0 grant hands priority to req1
    req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'h33;
    push(5'd12, 32'h33);
    tick();
    req0_valid = 1'b0;

    // x0 discard on req1: accepted, no write, priority back to req0
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFFFFFFFF;
    #1;
    chk("x0_ready1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_rd_loaded", 64'(rf_rd), 64'd0);
    chk("x0_wdata_loaded", 64'(rf_wdata), 64'hFFFFFFFF);
    chk("x0_busy", 64'(busy), 64'd0);
    req0_valid = 1'b1; req0_rd = 5'd13; req0_data = 32'h44;
    req1_valid = 1'b1; req1_rd = 5'd14; req1_data = 32'h55;
    #1;
    chk("x0_ptr_ready0", 64'(req0_ready), 64'd1);
    chk("x0_ptr_ready1", 64'(req1_ready), 64'd0);
    push(5'd13, 32'h44);
    tick();
    req0_valid = 1'b0;
    push(5'd14, 32'h55);
    tick();
    req1_valid = 1'b0;
    tick();

    // Scoreboard: mark r7, grant r7 two cycles later
    mark_valid = 1'b1; mark_rd = 5'd7;
    tick();
    mark_valid = 1'b0;
    chk("sb_busy7_set", 64'(busy[7]), 64'd1);
    tick();
    chk("sb_busy7_hold", 64'(busy[7]), 64'd1);
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
    push(5'd7, 32'h77);
    tick();
    req0_valid = 1'b0;
    chk("sb_busy7_clr", 64'(busy[7]), 64'd0);
    chk("sb_we_with_clr", 64'(rf_we), 64'd1);

    // Same-register set and clear: set wins
    mark_valid = 1'b1; mark_rd = 5'd9;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
    push(5'd9, 32'h99);
    tick();
    chk("sb_set_wins", 64'(busy[9]), 64'd1);

    // Different registers on the same edge: both apply
    mark_rd = 5'd10; req0_data = 32'h9A;
    push(5'd9, 32'h9A);
    tick();
    mark_valid = 1'b0; req0_valid = 1'b0;
    chk("sb_clr9", 64'(busy[9]), 64'd0);
    chk("sb_set10", 64'(busy[10]), 64'd1);

    // Marking x0 never sets busy[0]
    mark_valid = 1'b1; mark_rd = 5'd0;
    tick();
    mark_valid = 1'b0;
    chk("sb_x0_mark", 64'(busy[0]), 64'd0);
    chk("sb_final_vector", 64'(busy), 64'h0000_0400);

    tick(); tick();
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
